// File: rtl/tnn_pkg.sv
// Shared definitions for the ternary kernel path: 2-bit code points and the
// kernel unpack FSM state encoding.
package tnn_pkg;

    localparam logic [1:0] KCODE_ZERO = 2'b00;
    localparam logic [1:0] KCODE_POS  = 2'b01;
    localparam logic [1:0] KCODE_NEG  = 2'b11;
    localparam logic [1:0] KCODE_ILL  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/kernel_unpack_stream_lane_fix.sv
// kernel_lane_fix: per-beat lane cleanup. Lanes outside the mask are forced
// to zero. With KERNEL_ERR_CHECK_EN defined, unmasked illegal codes (10) are
// replaced by zero and reported on ill_hit; otherwise codes pass unchanged.
module kernel_lane_fix
    import tnn_pkg::*;
#(
    parameter int LANES        = 4,
    parameter int KERNEL_WIDTH = 2
) (
    input  logic [LANES*KERNEL_WIDTH-1:0] codes_in,
    input  logic [LANES-1:0]              mask,
    output logic [LANES*KERNEL_WIDTH-1:0] codes_out
`ifdef KERNEL_ERR_CHECK_EN
    ,
    output logic                          ill_hit
`endif
);

    // Zero masked-off lanes; optionally scrub illegal codes in live lanes.
    always_comb begin
        codes_out = '0;
`ifdef KERNEL_ERR_CHECK_EN
        ill_hit = 1'b0;
`endif
        for (int j = 0; j < LANES; j++) begin
            if (mask[j]) begin
`ifdef KERNEL_ERR_CHECK_EN
                if (codes_in[j*KERNEL_WIDTH +: KERNEL_WIDTH] == KCODE_ILL) begin
                    codes_out[j*KERNEL_WIDTH +: KERNEL_WIDTH] = KCODE_ZERO;
                    ill_hit = 1'b1;
                end else begin
                    codes_out[j*KERNEL_WIDTH +: KERNEL_WIDTH] = codes_in[j*KERNEL_WIDTH +: KERNEL_WIDTH];
                end
`else
                codes_out[j*KERNEL_WIDTH +: KERNEL_WIDTH] = codes_in[j*KERNEL_WIDTH +: KERNEL_WIDTH];
`endif
            end
        end
    end

endmodule

// File: rtl/kernel_unpack_stream.sv
// kernel_unpack_stream: takes packed ternary words from the weight buffer and
// streams them LANES codes per beat to the select units, with lane mask and
// last flag, for a programmed number of codes per job.
// Optional feature macro: KERNEL_ERR_CHECK_EN (illegal-code scrub + sticky err).
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. in_ready is high only in LOAD, out_valid only in EMIT; while
// out_valid is high and out_ready low the beat payload holds stable.
module kernel_unpack_stream
    import tnn_pkg::*;
#(
    parameter int KERNEL_WIDTH = 2,
    parameter int PACK_WIDTH   = 32,
    parameter int LANES        = 4,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [COUNT_WIDTH-1:0]        num_kernels,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [PACK_WIDTH-1:0]         in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*KERNEL_WIDTH-1:0] kernel_out,
    output logic [LANES-1:0]              lane_mask,
    output logic                          out_last,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [1:0]                    state_dbg
);

    localparam int CODES_PER_WORD = PACK_WIDTH / KERNEL_WIDTH;
    localparam int BEATS          = CODES_PER_WORD / LANES;
    localparam int BEAT_W         = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BEAT_BITS      = LANES * KERNEL_WIDTH;

    state_t                   state_q, state_d;
    logic [COUNT_WIDTH-1:0]   rem_q, rem_after, take, cand_rem;
    logic [BEAT_W-1:0]        beat_cnt_q;
    logic [PACK_WIDTH-1:0]    shift_q, cand_shift;
    logic                     load_beat;
    logic [LANES-1:0]         cand_mask;
    logic                     cand_last;
    logic [BEAT_BITS-1:0]     fix_out;
    logic [BEAT_BITS-1:0]     kernel_q;
    logic [LANES-1:0]         mask_q;
    logic                     last_q;

    // Codes consumed by the current beat and the count left afterwards.
    assign take      = (rem_q >= COUNT_WIDTH'(LANES)) ? COUNT_WIDTH'(LANES) : rem_q;
    assign rem_after = rem_q - take;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next state, plus which word/count the next beat is built from.
    always_comb begin
        state_d    = state_q;
        load_beat  = 1'b0;
        cand_shift = shift_q >> BEAT_BITS;
        cand_rem   = rem_after;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = (num_kernels != '0) ? ST_LOAD : ST_DONE;
            end
            ST_LOAD: begin
                if (in_valid) begin
                    state_d    = ST_EMIT;
                    load_beat  = 1'b1;
                    cand_shift = in_data;
                    cand_rem   = rem_q;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    if (rem_after == '0)                          state_d = ST_DONE;
                    else if (beat_cnt_q == BEAT_W'(BEATS - 1))    state_d = ST_LOAD;
                    else                                          load_beat = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Lane mask and last flag for the beat about to be registered.
    always_comb begin
        cand_mask = '0;
        for (int j = 0; j < LANES; j++) cand_mask[j] = (cand_rem > COUNT_WIDTH'(j));
        cand_last = (cand_rem <= COUNT_WIDTH'(LANES));
    end

`ifdef KERNEL_ERR_CHECK_EN
    logic fix_ill;
    logic ill_q;
    logic err_q;
`endif

    kernel_lane_fix #(
        .LANES        (LANES),
        .KERNEL_WIDTH (KERNEL_WIDTH)
    ) u_lane_fix (
        .codes_in  (cand_shift[BEAT_BITS-1:0]),
        .mask      (cand_mask),
        .codes_out (fix_out)
`ifdef KERNEL_ERR_CHECK_EN
        ,
        .ill_hit   (fix_ill)
`endif
    );

    // Job count, word shift register, beat counter and registered beat payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q      <= '0;
            beat_cnt_q <= '0;
            shift_q    <= '0;
            kernel_q   <= '0;
            mask_q     <= '0;
            last_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (start) rem_q <= num_kernels;
                ST_LOAD: begin
                    if (in_valid) begin
                        shift_q    <= in_data;
                        beat_cnt_q <= '0;
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        rem_q      <= rem_after;
                        shift_q    <= cand_shift;
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
            if (load_beat) begin
                kernel_q <= fix_out;
                mask_q   <= cand_mask;
                last_q   <= cand_last;
            end else if (state_q == ST_EMIT && out_ready) begin
                kernel_q <= '0;
                mask_q   <= '0;
                last_q   <= 1'b0;
            end
        end
    end

`ifdef KERNEL_ERR_CHECK_EN
    // Sticky error: set when a scrubbed beat is consumed, cleared by a new job.
    always_ff @(posedge clk) begin
        if (rst) begin
            ill_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            if (load_beat) ill_q <= fix_ill;
            if (state_q == ST_IDLE && start)                    err_q <= 1'b0;
            else if (state_q == ST_EMIT && out_ready && ill_q)  err_q <= 1'b1;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign in_ready   = (state_q == ST_LOAD);
    assign out_valid  = (state_q == ST_EMIT);
    assign kernel_out = kernel_q;
    assign lane_mask  = mask_q;
    assign out_last   = last_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_kernel_unpack_stream.sv
// Bench for kernel_unpack_stream: table-driven directed jobs, hand-written
// backpressure and mid-job reset sequences, and randomized jobs scored
// against a code-indexed reference model. Honours KERNEL_ERR_CHECK_EN.
module tb_kernel_unpack_stream;

    localparam int CW = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [CW-1:0] num_kernels;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  kernel_out;
    logic [3:0]  lane_mask;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  state_dbg;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    kernel_unpack_stream dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_kernels (num_kernels),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .kernel_out  (kernel_out),
        .lane_mask   (lane_mask),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .state_dbg   (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int          checks   = 0;
    int          failures = 0;
    logic [12:0] exp_q[$];   // {kernel, mask, last}
    logic [12:0] cap_q[$];
    logic [31:0] words[8];
    logic        exp_err;
    int          done_cyc, ir_cycles, ov_cycles, words_used;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic fail_msg(input string name);
        checks++;
        failures++;
        $display("FAIL %s got=absent exp=present", name);
    endtask

    // Reference model: code k of the job lives in word k/16, slot k%16;
    // beats group four consecutive codes; the final beat carries last.
    function automatic void build_model(input int n);
        int nb;
        logic [7:0]  kern;
        logic [3:0]  mask;
        logic [31:0] w;
        logic [1:0]  c;
        exp_q.delete();
        exp_err = 1'b0;
        nb = (n + 3) / 4;
        for (int b = 0; b < nb; b++) begin
            kern = '0;
            mask = '0;
            for (int j = 0; j < 4; j++) begin
                int k;
                k = b * 4 + j;
                if (k < n) begin
                    w = words[k / 16];
                    c = w[(k % 16) * 2 +: 2];
`ifdef KERNEL_ERR_CHECK_EN
                    if (c == 2'b10) begin
                        c = 2'b00;
                        exp_err = 1'b1;
                    end
`endif
                    kern[j*2 +: 2] = c;
                    mask[j] = 1'b1;
                end
            end
            exp_q.push_back({kern, mask, (b == nb - 1)});
        end
    endfunction

    // ---------------- driver ----------------
    // Runs one job: words[] supplies input, beats are scored as consumed.
    task automatic run_job(input int n, input bit rnd, input int stall_beat,
                           input int stall_len, input int budget);
        int          stall_left;
        logic        prev_stall, got_done;
        logic [12:0] prev_beat, beat, e;
        build_model(n);
        cap_q.delete();
        words_used = 0;
        stall_left = stall_len;
        prev_stall = 1'b0;
        prev_beat  = '0;
        got_done   = 1'b0;
        done_cyc   = -1;
        ir_cycles  = 0;
        ov_cycles  = 0;
        @(negedge clk);
        start = 1'b1; num_kernels = n[CW-1:0]; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("err_clear_on_start", {31'b0, err}, 32'd0);
        for (int cyc = 0; cyc < budget && !got_done; cyc++) begin
            beat = {kernel_out, lane_mask, out_last};
            if (prev_stall && out_valid) chk("bp_hold", {19'b0, beat}, {19'b0, prev_beat});
            if (in_ready && out_valid) fail_msg("ready_valid_overlap");
            if (in_ready)  ir_cycles++;
            if (out_valid) ov_cycles++;
            if (done) begin
                got_done = 1'b1;
                done_cyc = cyc;
            end
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
            else if (out_valid && cap_q.size() == stall_beat && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else out_ready = 1'b1;
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = words[words_used % 8];
            if (in_valid && in_ready) words_used++;
            if (out_valid && out_ready) begin
                cap_q.push_back(beat);
                if (exp_q.size() == 0) fail_msg("extra_beat");
                else begin
                    e = exp_q.pop_front();
                    chk("beat", {19'b0, beat}, {19'b0, e});
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_beat  = beat;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        if (!got_done) fail_msg("done_timeout");
        chk("beats_left", exp_q.size(), 32'd0);
        chk("words_used", words_used, (n + 15) / 16);
        chk("err_after_job", {31'b0, err}, {31'b0, exp_err});
        chk("done_single", {31'b0, done}, 32'd0);
        chk("busy_after", {31'b0, busy}, 32'd0);
    endtask

    typedef struct {
        int          n;
        logic [31:0] w0;
        logic [31:0] w1;
        int          nbeats;
        int          done_cyc;
        logic [31:0] k4;   // beat b kernel at [8b +: 8]
        logic [15:0] m4;   // beat b mask at [4b +: 4]
        logic [3:0]  l4;   // beat b last at [b]
        logic        err;
    } vec_t;

    vec_t vt[6];

    initial begin
        logic [12:0] cb;
        int nchk;
        rst = 1'b1; start = 1'b0; num_kernels = '0; in_valid = 1'b0;
        in_data = '0; out_ready = 1'b0;
        for (int i = 0; i < 8; i++) words[i] = '0;

        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'b0, in_ready},  32'd0);
        chk("rst_busy",      {31'b0, busy},      32'd0);
        chk("rst_outputs",   {19'b0, kernel_out, lane_mask, out_last}, 32'd0);
        chk("rst_state",     {30'b0, state_dbg}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed table: {n, w0, w1} -> beats, done timing, first four beats.
        vt[0] = '{16, 32'hFFFF_5555, 32'h0,         4, 5, 32'hFFFF_5555, 16'hFFFF, 4'b1000, 1'b0};
        vt[1] = '{6,  32'h0000_FF55, 32'h0,         2, 3, 32'h0000_0F55, 16'h003F, 4'b0010, 1'b0};
        vt[2] = '{20, 32'hFFFF_5555, 32'h1234_5671, 5, 7, 32'hFFFF_5555, 16'hFFFF, 4'b0000, 1'b0};
        vt[3] = '{0,  32'hFFFF_FFFF, 32'h0,         0, 0, 32'h0,         16'h0,    4'b0000, 1'b0};
`ifdef KERNEL_ERR_CHECK_EN
        vt[4] = '{3,  32'h0000_0036, 32'h0,         1, 2, 32'h0000_0034, 16'h0007, 4'b0001, 1'b1};
`else
        vt[4] = '{3,  32'h0000_0036, 32'h0,         1, 2, 32'h0000_0036, 16'h0007, 4'b0001, 1'b0};
`endif
        vt[5] = '{1,  32'h0000_0009, 32'h0,         1, 2, 32'h0000_0001, 16'h0001, 4'b0001, 1'b0};

        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 8; k++) words[k] = '0;
            words[0] = vt[i].w0;
            words[1] = vt[i].w1;
            run_job(vt[i].n, 1'b0, -1, 0, 200);
            chk("tbl_nbeats",   cap_q.size(), vt[i].nbeats);
            chk("tbl_done_cyc", done_cyc, vt[i].done_cyc);
            chk("tbl_in_ready_cycles", ir_cycles, (vt[i].n + 15) / 16);
            chk("tbl_out_valid_cycles", ov_cycles, vt[i].nbeats);
            nchk = (cap_q.size() < 4) ? cap_q.size() : 4;
            for (int b = 0; b < nchk; b++) begin
                cb = cap_q[b];
                chk("tbl_kernel", {24'b0, cb[12:5]}, {24'b0, vt[i].k4[8*b +: 8]});
                chk("tbl_mask",   {28'b0, cb[4:1]},  {28'b0, vt[i].m4[4*b +: 4]});
                chk("tbl_last",   {31'b0, cb[0]},    {31'b0, vt[i].l4[b]});
            end
            repeat (2) @(negedge clk);
            chk("tbl_err_sticky", {31'b0, err}, {31'b0, vt[i].err});
        end

        // Backpressure: three stalled cycles on beat 1 of the 16-code job.
        for (int k = 0; k < 8; k++) words[k] = '0;
        words[0] = 32'hFFFF_5555;
        run_job(16, 1'b0, 1, 3, 200);
        chk("stall_nbeats", cap_q.size(), 32'd4);
        chk("stall_done_cyc", done_cyc, 32'd8);

        // Reset while a beat is pending: job aborts with no done.
        words[0] = $urandom;
        @(negedge clk);
        start = 1'b1; num_kernels = 16'd16; in_valid = 1'b1; in_data = words[0]; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk);
        if (!out_valid) fail_msg("midrst_reach_emit");
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_outputs",   {19'b0, kernel_out, lane_mask, out_last}, 32'd0);
        chk("midrst_busy",      {31'b0, busy}, 32'd0);
        chk("midrst_done",      {31'b0, done}, 32'd0);
        chk("midrst_in_ready",  {31'b0, in_ready}, 32'd0);
        chk("midrst_state",     {30'b0, state_dbg}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_no_done", {31'b0, done}, 32'd0);
        end

        // Randomized jobs with random valid/ready and random code content.
        for (int t = 0; t < 25; t++) begin
            for (int k = 0; k < 8; k++) words[k] = $urandom;
            run_job($urandom_range(1, 100), 1'b1, -1, 0, 2000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/kernel_unpack_stream.md
Name: kernel_unpack_stream

Overview:
Producer end of the ternary kernel interface. It accepts packed ternary weight words from the weight buffer through a valid/ready handshake. It unpacks each word into LANES 2-bit kernel codes per beat and streams them with valid/ready, a lane mask and a last flag to a bank of select units. One job emits a programmed number of kernel codes, then pulses done.

Parameters:
KERNEL_WIDTH, 2, bits per ternary code (fixed at 2; encoding 01=+1, 11=-1, 00=0, 10=illegal)
PACK_WIDTH, 32, bits per packed input word; must be a multiple of LANES*KERNEL_WIDTH
LANES, 4, codes emitted per output beat
COUNT_WIDTH, 16, width of the job kernel count

Ports:
clk  input  1  clock
rst  input  1  reset; one clock, synchronous, active-high
start  input  1  job start pulse; sampled only in IDLE
num_kernels  input  COUNT_WIDTH  total codes for the job; latched on accepted start
in_valid  input  1  packed word valid
in_ready  output  1  word accepted when in_valid & in_ready
in_data  input  PACK_WIDTH  packed codes; code i at bits [i*KERNEL_WIDTH +: KERNEL_WIDTH]
out_valid  output  1  beat valid
out_ready  input  1  beat consumed when out_valid & out_ready
kernel_out  output  LANES*KERNEL_WIDTH  lane j at bits [j*KERNEL_WIDTH +: KERNEL_WIDTH]
lane_mask  output  LANES  1 = lane carries a real code
out_last  output  1  final beat of job
busy  output  1  high outside IDLE
done  output  1  one-cycle pulse at job end
err  output  1  sticky illegal-code flag (see Optional Feature)

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): state IDLE; all outputs 0; remaining count, beat counter and shift register cleared. Reset mid-job aborts the job with no done pulse.
- CODES_PER_WORD = PACK_WIDTH/KERNEL_WIDTH (16). BEATS = CODES_PER_WORD/LANES (4).
- Beat b of a word carries codes b*LANES .. b*LANES+LANES-1.
- FSM states: IDLE, LOAD, EMIT, DONE.
- IDLE:
  - start with num_kernels != 0 latches remaining = num_kernels and goes to LOAD.
  - start with num_kernels == 0 goes to DONE; no beats are emitted.
- LOAD: in_ready=1, out_valid=0. On handshake, capture in_data into the shift register, clear beat_cnt, go to EMIT. Latency is one cycle from word accept to out_valid.
- EMIT: out_valid=1 and all outputs are registered.
  - lane_mask = all ones if remaining >= LANES, else (1<<remaining)-1.
  - Masked-off lanes drive 00.
  - out_last = (remaining <= LANES).
- EMIT, on out_ready:
  - remaining -= min(LANES, remaining).
  - Shift register moves right by LANES*KERNEL_WIDTH.
  - If remaining reaches 0, go to DONE. Unused codes of the word are discarded.
  - Otherwise, if beat_cnt == BEATS-1, go to LOAD; else increment beat_cnt.
- Backpressure: while out_valid & !out_ready, kernel_out, lane_mask and out_last hold stable.
- DONE: done=1 for exactly one cycle, busy=1, then IDLE.
- start outside IDLE is ignored. in_valid outside LOAD is ignored (in_ready=0).
- Throughput: BEATS+1 cycles per full word with out_ready held high (one LOAD bubble).

Optional Feature:
- Macro KERNEL_ERR_CHECK_EN, defined:
  - Each unmasked lane holding 10 is driven as 00.
  - err sets on that beat's handshake and stays set until reset or an accepted start.
- Macro undefined:
  - Codes pass through unchanged, 10 included.
  - err is tied 0.

Decomposition:
- Shared package tnn_pkg:
  - KCODE_ZERO=2'b00, KCODE_POS=2'b01, KCODE_NEG=2'b11, KCODE_ILL=2'b10.
  - FSM state enum.
- One sub-module: kernel_lane_fix (combinational, per beat). It applies lane_mask zeroing and, under the macro, illegal-code replacement plus an illegal-hit flag.

Test Plan:
1. num_kernels=16, in_data=32'hFFFF_5555 -> four beats with kernel_out 0x55, 0x55, 0xFF, 0xFF; lane_mask 4'hF each; out_last on beat 4 only; done one cycle later.
2. num_kernels=6, in_data=32'h0000_FF55 -> beat 1 is 0x55 mask 4'hF; beat 2 is 0x0F mask 4'h3 with out_last; no third beat; done pulses.
3. num_kernels=20, two words -> four beats, then in_ready high for one LOAD cycle, then one beat with mask 4'hF and out_last.
4. out_ready low 3 cycles during beat 2 of test 1 -> kernel_out, lane_mask and out_last stable; the beat sequence is otherwise unchanged.
5. Word with code 10 in an unmasked lane:
   - Macro on: lane reads 00 and err latches 1 until the next start.
   - Macro off: lane reads 10 and err stays 0.
6. Further cases:
   - rst asserted mid-EMIT -> next cycle IDLE with all outputs 0 and no done.
   - start with num_kernels=0 -> done pulse one cycle after start, no out_valid, no in_ready.
